// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- writeback stage of the 5-stage core.
//
// This stage is the only writer of the register file write port. It accepts
// retiring instructions from the MEM stage over a valid/ready handshake. A
// non-load retires in the cycle after it is accepted. A load first waits for
// the data-memory response. The returned word is then aligned and
// sign/zero-extended before it retires. While a load is outstanding, its
// destination register is published so that decode can stall on a load-use
// hazard.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   mem_valid_mem          MEM stage presents an instruction
//   wb_ready_wb            WB can accept this cycle (low only while waiting on a load)
//   mem_rd_mem             destination register
//   mem_rd_wen_mem         instruction writes rd
//   mem_result_mem         ALU result; byte address for loads
//   mem_is_load_mem        instruction is a load
//   mem_ld_type_mem        load funct3 (LB/LH/LW/LBU/LHU)
//   dmem_rvalid            data-memory read response strobe
//   dmem_rdata             aligned 32-bit word containing the load address
//   reg_wen_wb/_waddr_wb/_wdata_wb  register file write port
//   ld_pend_wb, ld_pend_rd_wb       load-use hazard status for decode
//   ld_misalign_wb         one-cycle pulse when a bad load is dropped
//   ld_timeout_wb          sticky: some load was abandoned after LD_TIMEOUT cycles
//   retire_cnt_wb          retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int unsigned LD_TIMEOUT = 255,
  parameter int unsigned TO_W       = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid_mem,
  output logic             wb_ready_wb,
  input  logic [4:0]       mem_rd_mem,
  input  logic             mem_rd_wen_mem,
  input  logic [31:0]      mem_result_mem,
  input  logic             mem_is_load_mem,
  input  logic [2:0]       mem_ld_type_mem,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic             reg_wen_wb,
  output logic [4:0]       reg_waddr_wb,
  output logic [31:0]      reg_wdata_wb,
  output logic             ld_pend_wb,
  output logic [4:0]       ld_pend_rd_wb,
  output logic             ld_misalign_wb,
  output logic             ld_timeout_wb,
  output logic [CNT_W-1:0] retire_cnt_wb
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_RETIRE  = 2'd1,
    S_WAIT_LD = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(LD_TIMEOUT);

  // The result is {legal, extended_data}. A load is illegal when it is
  // misaligned for its size or when its funct3 is not a supported load type.
  function automatic logic [32:0] align_load(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [32:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {1'b1, {24{b[7]}}, b};
      3'b100:  r = {1'b1, 24'd0, b};
      3'b001:  r = {~off[0], {16{h[15]}}, h};
      3'b101:  r = {~off[0], 16'd0, h};
      3'b010:  r = {(off == 2'b00), word};
      default: r = {1'b0, 32'd0};
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [4:0]        rd_q, rd_d;
  logic              wen_q, wen_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        ld_type_q, ld_type_d;
  logic [31:0]       data_q, data_d;
  logic              drop_q, drop_d;
  logic              misalign_q, misalign_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  logic              accept_s;
  logic              retire_s;
  logic [32:0]       align_s;

  assign wb_ready_wb = (state_q != S_WAIT_LD);
  assign accept_s    = mem_valid_mem & wb_ready_wb;
  assign retire_s    = (state_q == S_RETIRE);
  assign align_s     = align_load(ld_type_q, addr_lo_q, dmem_rdata);

  // Next-state logic: accept/retire sequencing and load completion/timeout
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    addr_lo_d  = addr_lo_q;
    ld_type_d  = ld_type_q;
    data_d     = data_q;
    drop_d     = drop_q;
    misalign_d = misalign_q;
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_EMPTY, S_RETIRE: begin
        // RETIRE accepts too, so back-to-back non-loads retire one per cycle.
        if (accept_s) begin
          rd_d       = mem_rd_mem;
          wen_d      = mem_rd_wen_mem;
          addr_lo_d  = mem_result_mem[1:0];
          ld_type_d  = mem_ld_type_mem;
          data_d     = mem_result_mem;
          drop_d     = 1'b0;
          misalign_d = 1'b0;
          to_cnt_d   = '0;
          if (mem_is_load_mem) begin
            state_d = S_WAIT_LD;
          end else begin
            state_d = S_RETIRE;
          end
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_WAIT_LD: begin
        // A response wins over a timeout that expires in the same cycle.
        if (dmem_rvalid) begin
          state_d = S_RETIRE;
          if (align_s[32]) begin
            data_d     = align_s[31:0];
            drop_d     = 1'b0;
            misalign_d = 1'b0;
          end else begin
            data_d     = 32'd0;
            drop_d     = 1'b1;
            misalign_d = 1'b1;
          end
        end else if (to_cnt_q == TO_MAX) begin
          state_d    = S_RETIRE;
          data_d     = 32'd0;
          drop_d     = 1'b1;
          misalign_d = 1'b0;
          timeout_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  // The retire counter increments when RETIRE is entered, so the count already
  // includes the instruction that is being written back in that cycle.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (state_d == S_RETIRE) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // State register with synchronous reset that abandons any load in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      rd_q         <= 5'd0;
      wen_q        <= 1'b0;
      addr_lo_q    <= 2'd0;
      ld_type_q    <= 3'd0;
      data_q       <= 32'd0;
      drop_q       <= 1'b0;
      misalign_q   <= 1'b0;
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      wen_q        <= wen_d;
      addr_lo_q    <= addr_lo_d;
      ld_type_q    <= ld_type_d;
      data_q       <= data_d;
      drop_q       <= drop_d;
      misalign_q   <= misalign_d;
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // These outputs are decoded only from registered state. x0 is never written.
  assign reg_wen_wb     = retire_s & wen_q & (rd_q != 5'd0) & ~drop_q;
  assign reg_waddr_wb   = retire_s ? rd_q : 5'd0;
  assign reg_wdata_wb   = retire_s ? data_q : 32'd0;
  assign ld_pend_wb     = (state_q == S_WAIT_LD) & wen_q & (rd_q != 5'd0);
  assign ld_pend_rd_wb  = (state_q == S_WAIT_LD) ? rd_q : 5'd0;
  assign ld_misalign_wb = retire_s & misalign_q;
  assign ld_timeout_wb  = timeout_q;
  assign retire_cnt_wb  = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_mem;
  logic        wb_ready_wb;
  logic [4:0]  mem_rd_mem;
  logic        mem_rd_wen_mem;
  logic [31:0] mem_result_mem;
  logic        mem_is_load_mem;
  logic [2:0]  mem_ld_type_mem;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        reg_wen_wb;
  logic [4:0]  reg_waddr_wb;
  logic [31:0] reg_wdata_wb;
  logic        ld_pend_wb;
  logic [4:0]  ld_pend_rd_wb;
  logic        ld_misalign_wb;
  logic        ld_timeout_wb;
  logic [31:0] retire_cnt_wb;

  wb_stage #(.LD_TIMEOUT(4), .TO_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_mem(mem_valid_mem), .wb_ready_wb(wb_ready_wb),
    .mem_rd_mem(mem_rd_mem), .mem_rd_wen_mem(mem_rd_wen_mem),
    .mem_result_mem(mem_result_mem), .mem_is_load_mem(mem_is_load_mem),
    .mem_ld_type_mem(mem_ld_type_mem),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .reg_wen_wb(reg_wen_wb), .reg_waddr_wb(reg_waddr_wb), .reg_wdata_wb(reg_wdata_wb),
    .ld_pend_wb(ld_pend_wb), .ld_pend_rd_wb(ld_pend_rd_wb),
    .ld_misalign_wb(ld_misalign_wb), .ld_timeout_wb(ld_timeout_wb),
    .retire_cnt_wb(retire_cnt_wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic        mis;
    logic        tmo;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_skip = 1'b1;
  logic tmo_model = 1'b0;   // expected sticky timeout after the next retire of a timed-out load
  logic tmo_cur   = 1'b0;   // expected value of ld_timeout_wb right now
  logic [31:0] prev_cnt = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference load: shift the word down by the byte offset, then extend according to the load size.
  function automatic logic [32:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
    int unsigned sh;
    logic [31:0] v;
    logic [31:0] r;
    logic ok;
    sh = (addr % 4) * 8;
    v  = w >> sh;
    ok = 1'b0;
    r  = 32'd0;
    case (f3)
      3'd0: begin ok = 1'b1; r = v[7] ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF); end
      3'd4: begin ok = 1'b1; r = v & 32'hFF; end
      3'd1: begin ok = ((addr % 2) == 0); r = v[15] ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF); end
      3'd5: begin ok = ((addr % 2) == 0); r = v & 32'hFFFF; end
      3'd2: begin ok = ((addr % 4) == 0); r = w; end
      default: begin ok = 1'b0; r = 32'd0; end
    endcase
    return {ok, r};
  endfunction

  // Monitor: one scoreboard entry is popped at every retire, which the counter step marks.
  always @(negedge clk) begin
    exp_t e;
    if (mon_skip) begin
      prev_cnt = retire_cnt_wb;
    end else if (retire_cnt_wb != prev_cnt) begin
      chk("retire_cnt_step", retire_cnt_wb, prev_cnt + 32'd1);
      prev_cnt = retire_cnt_wb;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_retire actual=retire expected=none t=%0t", $time);
      end else begin
        e = sb.pop_front();
        tmo_cur = e.tmo;
        chk("wen", 32'(reg_wen_wb), 32'(e.wen));
        chk("waddr", 32'(reg_waddr_wb), 32'(e.rd));
        if (e.chk_data) chk("wdata", reg_wdata_wb, e.data);
        chk("misalign", 32'(ld_misalign_wb), 32'(e.mis));
        chk("timeout", 32'(ld_timeout_wb), 32'(e.tmo));
      end
    end else begin
      chk("idle_wen", 32'(reg_wen_wb), 32'd0);
      chk("idle_misalign", 32'(ld_misalign_wb), 32'd0);
      chk("idle_waddr_wdata", {27'd0, reg_waddr_wb} | reg_wdata_wb, 32'd0);
      chk("idle_timeout", 32'(ld_timeout_wb), 32'(tmo_cur));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic wen, input logic [31:0] res);
    exp_t e;
    mem_valid_mem = 1'b1; mem_rd_mem = rd; mem_rd_wen_mem = wen;
    mem_result_mem = res; mem_is_load_mem = 1'b0; mem_ld_type_mem = 3'(res);
    e.rd = rd; e.wen = wen && (rd != 5'd0); e.data = res; e.mis = 1'b0;
    e.tmo = tmo_model; e.chk_data = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    chk("ready_accept", 32'(wb_ready_wb), 32'd1);
    step();
    mem_valid_mem = 1'b0;
  endtask

  task automatic check_waiting(input logic [4:0] rd, input logic wen);
    @(negedge clk);
    chk("ready_wait", 32'(wb_ready_wb), 32'd0);
    chk("ld_pend", 32'(ld_pend_wb), 32'(wen && (rd != 5'd0)));
    chk("ld_pend_rd", 32'(ld_pend_rd_wb), 32'(rd));
  endtask

  // Run one load. A delay of -1 means the response never arrives and the load times out.
  // A push of 0 means reset will abandon the load, so no retire is expected.
  task automatic do_load(input logic [4:0] rd, input logic wen, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] w, input int delay,
                         input logic push);
    exp_t e;
    logic [32:0] m;
    m = ref_load(f3, addr, w);
    mem_valid_mem = 1'b1; mem_rd_mem = rd; mem_rd_wen_mem = wen;
    mem_result_mem = addr; mem_is_load_mem = 1'b1; mem_ld_type_mem = f3;
    e.rd = rd;
    if (delay < 0) begin
      tmo_model = 1'b1;
      e.wen = 1'b0; e.data = 32'd0; e.mis = 1'b0; e.chk_data = 1'b0;
    end else begin
      e.wen = m[32] && wen && (rd != 5'd0); e.data = m[31:0];
      e.mis = ~m[32]; e.chk_data = m[32];
    end
    e.tmo = tmo_model;
    if (push) sb.push_back(e);
    @(negedge clk);
    chk("ready_accept", 32'(wb_ready_wb), 32'd1);
    step();
    mem_valid_mem = 1'b0;
    mem_is_load_mem = 1'b0;
    if (!push) begin
      repeat (2) begin check_waiting(rd, wen); step(); end
    end else if (delay < 0) begin
      repeat (5) begin check_waiting(rd, wen); step(); end
    end else begin
      repeat (delay) begin check_waiting(rd, wen); step(); end
      dmem_rvalid = 1'b1; dmem_rdata = w;
      check_waiting(rd, wen);
      step();
      dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    end
  endtask

  task automatic late_rvalid();
    dmem_rvalid = 1'b1; dmem_rdata = $urandom;
    step();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("ready_after_late_rvalid", 32'(wb_ready_wb), 32'd1);
    step();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin step(); n++; end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; mem_valid_mem = 1'b0; mem_rd_mem = 5'd0; mem_rd_wen_mem = 1'b0;
    mem_result_mem = 32'd0; mem_is_load_mem = 1'b0; mem_ld_type_mem = 3'd0;
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_wen_addr_data", {26'd0, reg_wen_wb, reg_waddr_wb} | reg_wdata_wb, 32'd0);
    chk("rst_pend", {26'd0, ld_pend_wb, ld_pend_rd_wb}, 32'd0);
    chk("rst_flags", {30'd0, ld_misalign_wb, ld_timeout_wb}, 32'd0);
    chk("rst_cnt", retire_cnt_wb, 32'd0);
    step();
    rst = 1'b0;
    mon_skip = 1'b0;

    // Directed cases
    do_alu(5'd5, 1'b1, 32'h0000_1234);
    step();
    for (int i = 1; i <= 4; i++) do_alu(5'(i), 1'b1, 32'hA000_0000 + 32'(i));
    step();
    do_load(5'd7, 1'b1, 32'h0000_0103, 3'b000, 32'h80FF_FF00, 2, 1'b1);
    do_load(5'd7, 1'b1, 32'h0000_0102, 3'b101, 32'h80FF_FF00, 1, 1'b1);
    do_load(5'd8, 1'b1, 32'h0000_0102, 3'b010, 32'h1111_2222, 0, 1'b1);
    do_alu(5'd0, 1'b1, 32'hDEAD_BEEF);
    step();
    do_load(5'd9, 1'b1, 32'h0000_0200, 3'b010, 32'h0, -1, 1'b1);
    late_rvalid();
    wait_drain();

    // Randomised traffic
    for (int t = 0; t < 150; t++) begin
      int kind;
      logic [4:0] rd;
      logic wen;
      kind = int'($urandom_range(0, 9));
      rd = 5'($urandom_range(0, 31));
      wen = ($urandom_range(0, 7) != 0);
      if (kind <= 5) begin
        do_alu(rd, wen, $urandom);
      end else if (kind <= 8) begin
        do_load(rd, wen, $urandom, 3'($urandom_range(0, 7)), $urandom,
                int'($urandom_range(0, 3)), 1'b1);
      end else begin
        do_load(rd, wen, $urandom, 3'($urandom_range(0, 7)), $urandom, -1, 1'b1);
        if ($urandom_range(0, 1) == 1) late_rvalid();
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) step();
    end
    wait_drain();
    step();

    // Reset while waiting on a load: abandon it, clear everything, no write
    do_load(5'd11, 1'b1, 32'h0000_0300, 3'b010, 32'h0, 0, 1'b0);
    mon_skip = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready", 32'(wb_ready_wb), 32'd1);
    chk("rstw_wen_addr_data", {26'd0, reg_wen_wb, reg_waddr_wb} | reg_wdata_wb, 32'd0);
    chk("rstw_pend", {26'd0, ld_pend_wb, ld_pend_rd_wb}, 32'd0);
    chk("rstw_flags", {30'd0, ld_misalign_wb, ld_timeout_wb}, 32'd0);
    chk("rstw_cnt", retire_cnt_wb, 32'd0);
    tmo_model = 1'b0;
    tmo_cur = 1'b0;
    step();
    mon_skip = 1'b0;
    step();
    do_alu(5'd3, 1'b1, 32'h0BAD_F00D);
    wait_drain();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
